// File: rtl/dmem_hs.sv
// dmem_hs: handshaked, byte-addressable data memory for the xgriscv pipeline.
// Accepts one load/store at a time over valid/ready.
// Handles byte/half/word accesses with sign or zero extension.
// Returns a registered response LATENCY edges after the access.
// Optional feature macro: DMEM_MISALIGN_EN. When defined, accesses crossing a
// 4-byte boundary are split into two beats (the last word wraps to word 0).
// When undefined, misaligned half/word accesses are answered with resp_err.
module dmem_hs #(
    parameter int XLEN        = 32,
    parameter int DEPTH_BYTES = 4096,
    parameter int LATENCY     = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err
);

    localparam int LANES = XLEN / 8;
    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / LANES;
    localparam int IW    = AW - 2;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACC   = 3'd1,
`ifdef DMEM_MISALIGN_EN
        S_SPLIT = 3'd2,
`endif
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;

    logic            cap_we;
    logic            cap_uns;
    logic [AW-1:0]   cap_addr;
    logic [XLEN-1:0] cap_wdata;
    logic [1:0]      cap_size;

    logic [XLEN-1:0] mem [WORDS];

    logic [1:0]       off;
    logic [IW-1:0]    idx0;
    logic [LANES-1:0] bmask;
    logic [LANES-1:0] be_lo;
    logic [XLEN-1:0]  wd_lo;
    logic [XLEN-1:0]  rd_word0;
    logic             size_bad;
    logic             acc_err;
    logic             mem_we0;

    // Upper address bits alias onto the memory and are deliberately dropped.
    logic             unused_addr_bits;
    assign unused_addr_bits = ^req_addr[XLEN-1:AW];

    assign off      = cap_addr[1:0];
    assign idx0     = cap_addr[AW-1:2];
    assign size_bad = (cap_size == 2'b00);
    assign rd_word0 = mem[idx0];
    assign mem_we0  = (state == S_ACC) && cap_we && !acc_err && !reset;

`ifdef DMEM_MISALIGN_EN
    logic [IW-1:0]        idx1;
    logic [2:0]           nbytes;
    logic                 need_split;
    logic [2*XLEN-1:0]    wdata_wide;
    logic [2*LANES-1:0]   be_wide;
    logic [LANES-1:0]     be_hi;
    logic [XLEN-1:0]      wd_hi;
    logic [XLEN-1:0]      rd_word1;
    logic [XLEN-1:0]      beat0_word;
    logic                 mem_we1;

    // Beat 1 addresses the following word; incrementing in IW bits wraps the top word to 0.
    assign idx1       = idx0 + IW'(1);
    assign wdata_wide = {{XLEN{1'b0}}, cap_wdata} << {off, 3'b000};
    assign be_wide    = {{LANES{1'b0}}, bmask} << off;
    assign wd_lo      = wdata_wide[XLEN-1:0];
    assign wd_hi      = wdata_wide[2*XLEN-1:XLEN];
    assign be_lo      = be_wide[LANES-1:0];
    assign be_hi      = be_wide[2*LANES-1:LANES];
    assign rd_word1   = mem[idx1];
    assign acc_err    = size_bad;
    assign need_split = !size_bad && (({1'b0, off} + nbytes) > 3'd4);
    assign mem_we1    = (state == S_SPLIT) && cap_we && !reset;
`else
    logic misaligned;

    // Without splitting, any half/word that does not sit inside one word is refused.
    assign misaligned = ((cap_size == 2'b10) && off[0]) ||
                        ((cap_size == 2'b11) && (off != 2'b00));
    assign wd_lo      = cap_wdata << {off, 3'b000};
    assign be_lo      = bmask << off;
    assign acc_err    = size_bad || misaligned;
`endif

    // Decode access size into a lane mask (and byte count when splitting is possible).
    always_comb begin
        bmask = '0;
`ifdef DMEM_MISALIGN_EN
        nbytes = 3'd0;
`endif
        case (cap_size)
            2'b01: begin
                bmask = 4'b0001;
`ifdef DMEM_MISALIGN_EN
                nbytes = 3'd1;
`endif
            end
            2'b10: begin
                bmask = 4'b0011;
`ifdef DMEM_MISALIGN_EN
                nbytes = 3'd2;
`endif
            end
            2'b11: begin
                bmask = 4'b1111;
`ifdef DMEM_MISALIGN_EN
                nbytes = 3'd4;
`endif
            end
            default: begin
                bmask = 4'b0000;
            end
        endcase
    end

    // Align the two-word window to the request offset, truncate to size and extend.
    function automatic logic [XLEN-1:0] assemble(input logic [2*XLEN-1:0] pair,
                                                 input logic [1:0]        o,
                                                 input logic [1:0]        size,
                                                 input logic              uns);
        logic [XLEN-1:0] sh;
        sh = XLEN'(pair >> {o, 3'b000});
        case (size)
            2'b01:   assemble = {{(XLEN-8){~uns & sh[7]}}, sh[7:0]};
            2'b10:   assemble = {{(XLEN-16){~uns & sh[15]}}, sh[15:0]};
            2'b11:   assemble = sh;
            default: assemble = '0;
        endcase
    endfunction

    assign req_ready = (state == S_IDLE) && !reset;

    // Byte-lane storage; contents survive reset, and a reset mid-request blocks pending beats.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (mem_we0 && be_lo[l]) begin
                mem[idx0][8*l +: 8] <= wd_lo[8*l +: 8];
            end
`ifdef DMEM_MISALIGN_EN
            if (mem_we1 && be_hi[l]) begin
                mem[idx1][8*l +: 8] <= wd_hi[8*l +: 8];
            end
`endif
        end
    end

    // Request capture, beat sequencing, latency countdown and the registered response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            cap_we     <= 1'b0;
            cap_uns    <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_size   <= 2'b00;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
`ifdef DMEM_MISALIGN_EN
            beat0_word <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_uns   <= req_unsigned;
                        cap_addr  <= req_addr[AW-1:0];
                        cap_wdata <= req_wdata;
                        cap_size  <= req_size;
                        state     <= S_ACC;
                    end
                end
                S_ACC: begin
                    resp_err   <= acc_err;
                    resp_rdata <= (cap_we || acc_err) ? '0 :
                                  assemble({{XLEN{1'b0}}, rd_word0}, off, cap_size, cap_uns);
                    if (LATENCY > 1) begin
                        wait_cnt <= CW'(LATENCY - 1);
                        state    <= S_WAIT;
                    end else begin
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end
`ifdef DMEM_MISALIGN_EN
                    // A crossing access overrides the completion path above and runs beat 1 next.
                    if (need_split) begin
                        beat0_word <= rd_word0;
                        resp_valid <= 1'b0;
                        state      <= S_SPLIT;
                    end
`endif
                end
`ifdef DMEM_MISALIGN_EN
                S_SPLIT: begin
                    resp_err   <= 1'b0;
                    resp_rdata <= cap_we ? '0 :
                                  assemble({rd_word1, beat0_word}, off, cap_size, cap_uns);
                    if (LATENCY > 1) begin
                        wait_cnt <= CW'(LATENCY - 1);
                        state    <= S_WAIT;
                    end else begin
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end
                end
`endif
                S_WAIT: begin
                    if (wait_cnt <= CW'(1)) begin
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
